pot_mac_sequencer: RTL
======================

Name: pot_mac_sequencer

Overview:
Sequences one unsigned_pot_shift power-of-two multiplier through a dot-product job: accept a length, stream LEN input/weight pairs over a valid/ready handshake, and accumulate the signed products. The result is then presented on an output valid/ready handshake. The block sits between the activation/weight fetch logic and the neuron output stage, so the shifter is reused across every term of a dot product.

Parameters:
INPUT_BIT_WIDTH, 4, unsigned activation width
WEIGHT_BIT_WIDTH, 4, weight width; MSB = sign (1 = negative), low bits = shift exponent
PROD_BIT_WIDTH, INPUT_BIT_WIDTH + 2**(WEIGHT_BIT_WIDTH-1), signed product width (12 at defaults)
ACC_BIT_WIDTH, 16, signed accumulator width, must be >= PROD_BIT_WIDTH
LEN_WIDTH, 8, job length counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  job request, sampled only in IDLE
len  in  LEN_WIDTH  number of pairs, sampled with start
abort  in  1  synchronous job cancel
busy  out  1  high whenever state != IDLE
in_valid  in  1  pair valid
in_ready  out  1  pair accepted when in_valid && in_ready
in_data  in  INPUT_BIT_WIDTH  unsigned activation
in_weight  in  WEIGHT_BIT_WIDTH  sign/exponent weight
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid && out_ready
out_acc  out  ACC_BIT_WIDTH  signed dot-product result
out_sat  out  1  sticky: any saturation occurred during this job

Behaviour:
- Reset (rst_n low at an edge): state IDLE; acc, count, busy, in_ready, out_valid, out_acc and out_sat all 0. This applies from any state, and a partial job is discarded.
- States are IDLE, ACCUM and DONE.
- IDLE: in_ready = 0, out_valid = 0.
  - start=1 with len>0: next state ACCUM; acc <= 0, sat <= 0, count <= len.
  - start=1 with len=0: next state DONE; acc <= 0, sat <= 0.
- ACCUM: in_ready = 1 (combinational from state).
  - Each handshake: acc <= sat_add(acc, product); count <= count-1.
  - Handshake while count==1: next state DONE.
  - Cycles with in_valid=0 hold all state.
- DONE: out_valid = 1; out_acc and out_sat driven from registers and held stable until out_ready=1. That handshake returns the block to IDLE.
- start is ignored outside IDLE. A new start is legal in the cycle after the out handshake.
- abort=1 in any state: next state IDLE, out_valid drops, nothing is emitted. abort wins over start, over an in handshake and over an out handshake in the same cycle.
- Product: in_data and in_weight drive unsigned_pot_shift combinationally. product = (weight MSB ? -1 : +1) * in_data * 2**weight[low bits], sign-extended to ACC_BIT_WIDTH. weight 1000 gives -0 = 0.
- Saturating add: a positive overflow clamps to 2**(ACC-1)-1 and a negative overflow clamps to -2**(ACC-1). Either sets the sticky sat bit, which clears only at job start.
- Latency: with start at cycle 0 and in_valid held high, pairs are accepted in cycles 1..LEN and out_valid is first high in cycle LEN+1. For len=0, out_valid is high in cycle 1.
- count never wraps: ACCUM is only entered with count >= 1.

Decomposition:
- Package pot_mac_pkg:
  - state enum {IDLE, ACCUM, DONE}
  - localparam functions for PROD_BIT_WIDTH
  - ACC_MAX/ACC_MIN constants
  - sat_add function
- Sub-module: one instance of the existing unsigned_pot_shift, with OUTPUT_BIT_WIDTH = PROD_BIT_WIDTH.
- Everything else (FSM, counter, accumulator) lives in pot_mac_sequencer.

Test Plan:
- Basic job: len=3, pairs (3,0001)=+6, (5,1010)=-20, (15,0111)=+1920, in_valid held high. Expect out_valid in cycle 4, out_acc=1906, out_sat=0, busy high in cycles 1-4.
- Empty job: start with len=0. Expect out_valid in cycle 1, out_acc=0, out_sat=0, no in_ready pulse.
- Saturation: len=18 of (15,0111). Expect out_acc=32767, out_sat=1. Then len=18 of (15,1111): expect out_acc=-32768, out_sat=1, sat cleared at that job's start.
- Backpressure: len=2 with one idle cycle between pairs, out_ready low for 5 cycles, start pulsed during DONE.
  - Result appears one cycle later than unstalled.
  - out_acc stays stable.
  - The start pulse is ignored.
  - Return to IDLE in the cycle after out_ready rises.
- Abort: len=4, abort after 2 accepted pairs. Expect IDLE next cycle and no out_valid. A following job len=1 with (1,0000) gives out_acc=1.
- Mid-job reset: rst_n low for one edge during ACCUM. Expect all outputs 0 and IDLE. A following len=1 with (2,0011) gives out_acc=16.

Source files
------------

// File: rtl/pot_mac_pkg.sv
// Shared types, width helpers and saturating arithmetic for the
// power-of-two MAC sequencer.
package pot_mac_pkg;

    // Job sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width used for intermediate arithmetic so any accumulator up to 63 bits
    // can be added without losing the carry out of the top bit.
    localparam int CALC_WIDTH = 64;

    // Default accumulator width, used for the ACC_MAX/ACC_MIN constants below.
    localparam int DEFAULT_ACC_BIT_WIDTH = 16;

    // Result of a saturating add: clamped value plus a flag saying a clamp happened.
    typedef struct packed {
        logic               sat;
        logic signed [63:0] value;
    } sat_result_t;

    // Signed product width: the unsigned activation shifted left by at most
    // 2**(w_w-1)-1 places, plus one sign bit.
    function automatic int prod_width(input int in_w, input int w_w);
        return in_w + (1 << (w_w - 1));
    endfunction

    // Largest positive value representable in a w-bit two's complement word.
    function automatic logic signed [63:0] acc_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative value representable in a w-bit two's complement word.
    function automatic logic signed [63:0] acc_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    localparam logic signed [63:0] ACC_MAX = acc_max(DEFAULT_ACC_BIT_WIDTH);
    localparam logic signed [63:0] ACC_MIN = acc_min(DEFAULT_ACC_BIT_WIDTH);

    // Adds two sign-extended operands and clamps the sum into a w-bit signed
    // range; the sat flag reports whether either bound was hit.
    function automatic sat_result_t sat_add(input logic signed [63:0] a,
                                            input logic signed [63:0] b,
                                            input int                 w);
        sat_result_t        result;
        logic signed [64:0] sum;
        logic signed [64:0] max_v;
        logic signed [64:0] min_v;
        sum          = 65'(a) + 65'(b);
        max_v        = 65'(acc_max(w));
        min_v        = 65'(acc_min(w));
        result.sat   = 1'b0;
        result.value = 64'(sum);
        if (sum > max_v) begin
            result.sat   = 1'b1;
            result.value = 64'(max_v);
        end else if (sum < min_v) begin
            result.sat   = 1'b1;
            result.value = 64'(min_v);
        end
        return result;
    endfunction

endpackage

// File: rtl/unsigned_pot_shift.sv
// Power-of-two multiplier: an unsigned activation times a weight whose MSB
// is a sign and whose low bits are a left-shift exponent. Purely combinational.
module unsigned_pot_shift #(
    parameter int INPUT_BIT_WIDTH  = 4,
    parameter int WEIGHT_BIT_WIDTH = 4,
    parameter int OUTPUT_BIT_WIDTH = INPUT_BIT_WIDTH + (1 << (WEIGHT_BIT_WIDTH - 1))
) (
    input  logic        [INPUT_BIT_WIDTH-1:0]  data,
    input  logic        [WEIGHT_BIT_WIDTH-1:0] weight,
    output logic signed [OUTPUT_BIT_WIDTH-1:0] result
);

    logic [OUTPUT_BIT_WIDTH-1:0] magnitude;
    logic [OUTPUT_BIT_WIDTH-1:0] shifted;

    // Widen, shift by the exponent, then apply the sign; a negative zero
    // weight naturally yields zero because -0 == 0.
    always_comb begin
        magnitude = {{(OUTPUT_BIT_WIDTH - INPUT_BIT_WIDTH){1'b0}}, data};
        shifted   = magnitude << weight[WEIGHT_BIT_WIDTH-2:0];
        if (weight[WEIGHT_BIT_WIDTH-1]) begin
            result = -$signed(shifted);
        end else begin
            result = $signed(shifted);
        end
    end

endmodule

// File: rtl/pot_mac_sequencer.sv
// Dot-product sequencer: accepts a job length, streams activation/weight
// pairs through one shared power-of-two multiplier, accumulates the signed
// products with saturation and presents the result on a valid/ready port.
module pot_mac_sequencer
    import pot_mac_pkg::*;
#(
    parameter int INPUT_BIT_WIDTH  = 4,
    parameter int WEIGHT_BIT_WIDTH = 4,
    parameter int PROD_BIT_WIDTH   = prod_width(INPUT_BIT_WIDTH, WEIGHT_BIT_WIDTH),
    parameter int ACC_BIT_WIDTH    = 16,
    parameter int LEN_WIDTH        = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic        [LEN_WIDTH-1:0] len,
    input  logic                        abort,
    output logic                        busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic  [INPUT_BIT_WIDTH-1:0] in_data,
    input  logic [WEIGHT_BIT_WIDTH-1:0] in_weight,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_BIT_WIDTH-1:0] out_acc,
    output logic                        out_sat
);

    state_t state;
    state_t state_next;

    logic signed [ACC_BIT_WIDTH-1:0]  acc;
    logic signed [ACC_BIT_WIDTH-1:0]  acc_next;
    logic                             sat;
    logic                             sat_next;
    logic        [LEN_WIDTH-1:0]      count;
    logic        [LEN_WIDTH-1:0]      count_next;
    logic signed [PROD_BIT_WIDTH-1:0] product;
    sat_result_t                      add_res;

    // The single shared multiplier; its result feeds the accumulator adder.
    unsigned_pot_shift #(
        .INPUT_BIT_WIDTH  (INPUT_BIT_WIDTH),
        .WEIGHT_BIT_WIDTH (WEIGHT_BIT_WIDTH),
        .OUTPUT_BIT_WIDTH (PROD_BIT_WIDTH)
    ) u_shift (
        .data   (in_data),
        .weight (in_weight),
        .result (product)
    );

    // Candidate accumulator update: both operands sign-extended before the
    // clamped add so overflow is detected rather than wrapping.
    assign add_res = sat_add(64'(acc), 64'(product), ACC_BIT_WIDTH);

    // Handshake outputs are decoded purely from the current state.
    assign busy      = (state != IDLE);
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_acc   = acc;
    assign out_sat   = sat;

    // State, accumulator, sticky saturation flag and remaining-pair counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            sat   <= 1'b0;
            count <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            sat   <= sat_next;
            count <= count_next;
        end
    end

    // Next-state and datapath update; abort takes priority over every
    // handshake and over start, and simply drops the job in progress.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        sat_next   = sat;
        count_next = count;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc_next = '0;
                        sat_next = 1'b0;
                        if (len != '0) begin
                            count_next = len;
                            state_next = ACCUM;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_next   = ACC_BIT_WIDTH'(add_res.value);
                        sat_next   = sat | add_res.sat;
                        count_next = count - LEN_WIDTH'(1);
                        if (count == LEN_WIDTH'(1)) begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule
